// File: rtl/startup_seq_pkg.sv
// ---------------------------------------------------------------------------
// startup_seq_pkg
//   Shared types and helpers for the board-level startup sequencer.
//   - seq_state_t : sequencer FSM states
//   - chan_idx_w  : width of a channel index (fail_chan, current channel)
// ---------------------------------------------------------------------------
package startup_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        RELEASE,
        GAP,
        START,
        RUN,
        DONE,
        ERROR
    } seq_state_t;

    // A single-channel build still needs a 1-bit index port.
    function automatic int chan_idx_w(input int num_chan);
        return (num_chan > 1) ? $clog2(num_chan) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchroniser for a bus of independent level signals.
//   Ports:
//     clock  in  1      destination clock
//     reset  in  1      asynchronous, active-low reset (clears both stages)
//     d      in  WIDTH  asynchronous input levels
//     q      out WIDTH  synchronised levels, two clock edges of latency
// ---------------------------------------------------------------------------
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/startup_sequencer.sv
// ---------------------------------------------------------------------------
// startup_sequencer
//   Holds NUM_CHAN downstream blocks in reset, releases them one at a time
//   (channel 0 first), waits for each channel's ready flag with a timeout,
//   spaces releases by a gap, then fires one start pulse and watches done.
//   Ports:
//     clock       in   1         system clock
//     reset       in   1         asynchronous, active-low reset
//     restart     in   1         sync pulse: re-run the sequence from HOLD
//     chan_ready  in   NUM_CHAN  per-channel ready, asynchronous to clock
//     chan_rst_n  out  NUM_CHAN  per-channel active-low reset, registered
//     start_port  out  1         one-cycle start pulse (START state)
//     done_port   in   1         main interface done level, synchronous
//     seq_busy    out  1         HOLD / RELEASE / GAP
//     seq_done    out  1         DONE
//     seq_error   out  1         ERROR (held until restart or reset)
//     fail_chan   out  idx       failing channel, valid with seq_error
// ---------------------------------------------------------------------------
module startup_sequencer
    import startup_seq_pkg::*;
#(
    parameter int NUM_CHAN      = 4,
    parameter int CNT_W         = 24,
    parameter int HOLD_CYCLES   = 1024,
    parameter int GAP_CYCLES    = 64,
    parameter int READY_TIMEOUT = 100000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            restart,
    input  logic [NUM_CHAN-1:0]             chan_ready,
    output logic [NUM_CHAN-1:0]             chan_rst_n,
    output logic                            start_port,
    input  logic                            done_port,
    output logic                            seq_busy,
    output logic                            seq_done,
    output logic                            seq_error,
    output logic [chan_idx_w(NUM_CHAN)-1:0] fail_chan
);

    localparam int               IDX_W   = chan_idx_w(NUM_CHAN);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CHAN - 1);
    localparam longint           CNT_MAX = (longint'(1) << CNT_W) - 1;

    // Reject parameter sets the shared counter cannot represent.
    if (NUM_CHAN < 1 || HOLD_CYCLES < 1 || GAP_CYCLES < 1 || READY_TIMEOUT < 1 ||
        HOLD_CYCLES > CNT_MAX || GAP_CYCLES > CNT_MAX || READY_TIMEOUT > CNT_MAX)
    begin : g_param_err
        $error("startup_sequencer: parameter out of range for CNT_W");
    end

    seq_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ch_q, ch_d;
    logic [IDX_W-1:0]    fail_q, fail_d;
    logic [NUM_CHAN-1:0] rst_n_q, rst_n_d;

    logic [NUM_CHAN-1:0] ready;
    logic [NUM_CHAN-1:0] mon_mask;
    logic [NUM_CHAN-1:0] dropped;
    logic                drop_any;
    logic [IDX_W-1:0]    drop_idx;
    logic                cnt_zero;

    // Counter value loaded on entry to each state.
    function automatic logic [CNT_W-1:0] load_val(input seq_state_t s);
        case (s)
            HOLD:    return CNT_W'(HOLD_CYCLES - 1);
            RELEASE: return CNT_W'(READY_TIMEOUT - 1);
            GAP:     return CNT_W'(GAP_CYCLES - 1);
            default: return '0;
        endcase
    endfunction

    sync_2ff #(
        .WIDTH (NUM_CHAN)
    ) u_ready_sync (
        .clock (clock),
        .reset (reset),
        .d     (chan_ready),
        .q     (ready)
    );

    assign cnt_zero = (cnt_q == '0);

    // Channels whose ready is supervised: in GAP every channel released so
    // far (0..ch, all of which have already reported ready), in RUN all.
    // RELEASE is unsupervised; DONE deliberately ignores ready loss.
    always_comb begin
        mon_mask = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            mon_mask[i] = (state_q == RUN) || ((state_q == GAP) && (i <= int'(ch_q)));
        end
        dropped  = mon_mask & ~ready;
        drop_any = |dropped;
        // Descending scan so the lowest dropped index is the one kept.
        drop_idx = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (dropped[i]) drop_idx = IDX_W'(i);
        end
    end

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= HOLD;
        else        state_q <= state_d;
    end

    // -----------------------------------------------------------------
    // Next-state logic (restart overrides everything)
    // -----------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        fail_d  = fail_q;
        if (restart) begin
            state_d = HOLD;
            ch_d    = '0;
            fail_d  = '0;
        end else begin
            case (state_q)
                HOLD: begin
                    if (cnt_zero) begin
                        state_d = RELEASE;
                        ch_d    = '0;
                    end
                end
                RELEASE: begin
                    // Ready is checked first so it wins a tie with the timeout.
                    if (ready[ch_q]) begin
                        state_d = GAP;
                    end else if (cnt_zero) begin
                        state_d = ERROR;
                        fail_d  = ch_q;
                    end
                end
                GAP: begin
                    if (drop_any) begin
                        state_d = ERROR;
                        fail_d  = drop_idx;
                    end else if (cnt_zero) begin
                        if (ch_q == LAST_CH) begin
                            state_d = START;
                        end else begin
                            state_d = RELEASE;
                            ch_d    = ch_q + 1'b1;
                        end
                    end
                end
                START: state_d = RUN;
                RUN: begin
                    if (drop_any) begin
                        state_d = ERROR;
                        fail_d  = drop_idx;
                    end else if (done_port) begin
                        state_d = DONE;
                    end
                end
                default: state_d = state_q;  // DONE / ERROR hold until restart
            endcase
        end
    end

    // Counter and per-channel reset outputs, computed from the transition.
    always_comb begin
        cnt_d   = cnt_q;
        rst_n_d = rst_n_q;
        if (restart || (state_d != state_q)) begin
            cnt_d = load_val(state_d);
        end else if (((state_q == HOLD) || (state_q == RELEASE) || (state_q == GAP)) && !cnt_zero) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (restart) begin
            rst_n_d = '0;
        end else if ((state_d == RELEASE) && (state_q != RELEASE)) begin
            rst_n_d[ch_d] = 1'b1;
        end else if ((state_d == ERROR) && (state_q != ERROR)) begin
            // Lower channels keep their state; the failing one and above go back into reset.
            for (int i = 0; i < NUM_CHAN; i++) begin
                if (i >= int'(fail_d)) rst_n_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
            ch_q    <= '0;
            fail_q  <= '0;
            rst_n_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            ch_q    <= ch_d;
            fail_q  <= fail_d;
            rst_n_q <= rst_n_d;
        end
    end

    // -----------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------
    always_comb begin
        start_port = (state_q == START);
        seq_busy   = (state_q == HOLD) || (state_q == RELEASE) || (state_q == GAP);
        seq_done   = (state_q == DONE);
        seq_error  = (state_q == ERROR);
        chan_rst_n = rst_n_q;
        fail_chan  = fail_q;
    end

endmodule

// File: tb/tb_startup_sequencer.sv
module tb_startup_sequencer;

    localparam int NC   = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int TMO  = 100;
    localparam int CW   = 8;

    logic          clock = 1'b0;
    logic          reset, restart, done_port;
    logic [NC-1:0] chan_ready, chan_rst_n;
    logic          start_port, seq_busy, seq_done, seq_error;
    logic [1:0]    fail_chan;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    // ready model: channel i's ready is first sampled dly[i] edges after its release
    int            dly[NC];
    int            age[NC];
    logic [NC-1:0] kill;

    // event log
    int            rise[NC];
    int            start_cnt, start_at, err_at;
    logic [NC-1:0] prev_rst;
    logic          prev_err;

    // predictions
    int p_rel[NC];
    int p_start, p_err, p_fch;

    startup_sequencer #(
        .NUM_CHAN      (NC),
        .CNT_W         (CW),
        .HOLD_CYCLES   (HOLD),
        .GAP_CYCLES    (GAP),
        .READY_TIMEOUT (TMO)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .restart    (restart),
        .chan_ready (chan_ready),
        .chan_rst_n (chan_rst_n),
        .start_port (start_port),
        .done_port  (done_port),
        .seq_busy   (seq_busy),
        .seq_done   (seq_done),
        .seq_error  (seq_error),
        .fail_chan  (fail_chan)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d required below 100000", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge, update the ready model, log events.
    task automatic step();
        @(negedge clock);
        for (int i = 0; i < NC; i++) begin
            if (chan_rst_n[i]) age[i] = age[i] + 1;
            else               age[i] = 0;
            chan_ready[i] = chan_rst_n[i] && (age[i] >= dly[i]) && !kill[i];
            if (chan_rst_n[i] && !prev_rst[i] && rise[i] < 0) rise[i] = cyc;
        end
        prev_rst = chan_rst_n;
        if (start_port) begin
            start_cnt++;
            start_at = cyc;
        end
        if (seq_error && !prev_err && err_at < 0) err_at = cyc;
        prev_err = seq_error;
    endtask

    task automatic clear_log();
        for (int i = 0; i < NC; i++) rise[i] = -1;
        start_cnt = 0;
        start_at  = -1;
        err_at    = -1;
        prev_rst  = chan_rst_n;
        prev_err  = seq_error;
    endtask

    // Timeline from the rules: release 0 after HOLD cycles; ready seen two
    // synchroniser edges after it is first sampled; next release GAP later.
    task automatic predict(input int base);
        int  t;
        bit  stop;
        t = base + HOLD;
        stop = 0;
        p_start = -1;
        p_err = -1;
        p_fch = 0;
        for (int i = 0; i < NC; i++) begin
            p_rel[i] = -1;
            if (!stop) begin
                p_rel[i] = t;
                if (dly[i] + 2 > TMO) begin
                    p_err = t + TMO;
                    p_fch = i;
                    stop = 1;
                end else begin
                    t = t + dly[i] + 2 + GAP;
                end
            end
        end
        if (!stop) p_start = t;
    endtask

    task automatic run_and_check(input string tag, input int base);
        int end_c;
        predict(base);
        end_c = (p_err >= 0) ? p_err : p_start;
        while (cyc < end_c + 3) step();
        for (int i = 0; i < NC; i++) chk($sformatf("%s rel%0d", tag, i), rise[i], p_rel[i]);
        chk({tag, " start_cnt"}, start_cnt, (p_err < 0) ? 1 : 0);
        if (p_err < 0) chk({tag, " start_at"}, start_at, p_start);
        chk({tag, " err_at"}, err_at, p_err);
        chk({tag, " seq_error"}, seq_error, (p_err >= 0) ? 1 : 0);
        if (p_err >= 0) chk({tag, " fail_chan"}, fail_chan, p_fch);
        chk({tag, " chan_rst_n"}, chan_rst_n, (p_err >= 0) ? ((1 << p_fch) - 1) : 32'hF);
        chk({tag, " seq_busy"}, seq_busy, 0);
        chk({tag, " seq_done"}, seq_done, 0);
    endtask

    task automatic do_restart(input string tag, output int base);
        restart = 1'b1;
        step();
        restart = 1'b0;
        base = cyc;
        chk({tag, " rst chan_rst_n"}, chan_rst_n, 0);
        chk({tag, " rst seq_error"}, seq_error, 0);
        chk({tag, " rst seq_done"}, seq_done, 0);
        chk({tag, " rst seq_busy"}, seq_busy, 1);
        clear_log();
    endtask

    // Called just after a negedge: pulse reset well clear of any clock edge.
    task automatic async_reset(input string tag, output int base);
        #2 reset = 1'b0;
        #1;
        chk({tag, " chan_rst_n"}, chan_rst_n, 0);
        chk({tag, " seq_done"}, seq_done, 0);
        chk({tag, " seq_error"}, seq_error, 0);
        chk({tag, " seq_busy"}, seq_busy, 1);
        chk({tag, " fail_chan"}, fail_chan, 0);
        #1 reset = 1'b1;
        base = cyc;
        for (int i = 0; i < NC; i++) age[i] = 0;
        chan_ready = '0;
        clear_log();
    endtask

    task automatic rand_dly();
        for (int i = 0; i < NC; i++) dly[i] = $urandom_range(1, 12);
    endtask

    initial begin
        int base;
        int k;
        reset = 1'b0;
        restart = 1'b0;
        done_port = 1'b0;
        kill = '0;
        chan_ready = '0;
        for (int i = 0; i < NC; i++) begin
            dly[i] = 5;
            age[i] = 0;
        end
        clear_log();
        repeat (3) step();

        // reset state
        chk("reset chan_rst_n", chan_rst_n, 0);
        chk("reset start_port", start_port, 0);
        chk("reset seq_busy", seq_busy, 1);
        chk("reset seq_done", seq_done, 0);
        chk("reset seq_error", seq_error, 0);
        chk("reset fail_chan", fail_chan, 0);

        // 1: ready 5 cycles after each release
        reset = 1'b1;
        base = cyc;
        clear_log();
        run_and_check("basic", base);
        done_port = 1'b1;
        step();
        done_port = 1'b0;
        chk("basic seq_done", seq_done, 1);
        step();
        chk("basic done held", seq_done, 1);

        // 6: ready loss in DONE is ignored
        kill[0] = 1'b1;
        repeat (6) step();
        chk("done drop seq_done", seq_done, 1);
        chk("done drop seq_error", seq_error, 0);
        chk("done drop start_cnt", start_cnt, 1);

        // async reset out of DONE, then a full sequence again
        async_reset("async done", base);
        kill = '0;
        run_and_check("post async", base);

        // random ready delays
        for (int r = 0; r < 3; r++) begin
            rand_dly();
            do_restart($sformatf("rnd%0d", r), base);
            run_and_check($sformatf("rnd%0d", r), base);
            done_port = 1'b1;
            step();
            done_port = 1'b0;
            chk($sformatf("rnd%0d seq_done", r), seq_done, 1);
        end

        // 2: channel 2 never ready
        rand_dly();
        dly[2] = 1000;
        do_restart("no_rdy2", base);
        run_and_check("no_rdy2", base);
        repeat (5) step();
        chk("no_rdy2 error held", seq_error, 1);
        chk("no_rdy2 no start", start_cnt, 0);

        // restart out of ERROR
        rand_dly();
        do_restart("from_err", base);
        run_and_check("from_err", base);

        // 4: ready and timeout coincide -> ready wins; one later -> timeout
        for (int i = 0; i < NC; i++) dly[i] = 5;
        dly[1] = TMO - 2;
        do_restart("tie", base);
        run_and_check("tie", base);
        dly[1] = TMO - 1;
        do_restart("tmo1", base);
        run_and_check("tmo1", base);

        // 3: two channels drop ready together in RUN
        rand_dly();
        do_restart("drop2", base);
        run_and_check("drop2", base);
        kill = 4'b1010;
        step();
        k = cyc;
        while (cyc < k + 5) step();
        chk("drop2 err_at", err_at, k + 3);
        chk("drop2 fail_chan", fail_chan, 1);
        chk("drop2 chan_rst_n", chan_rst_n, 4'b0001);
        chk("drop2 seq_error", seq_error, 1);
        kill = '0;

        // 5: restart during GAP of channel 1
        for (int i = 0; i < NC; i++) dly[i] = 5;
        do_restart("gap1", base);
        predict(base);
        k = p_rel[1] + dly[1] + 4;
        while (cyc < k) step();
        chk("gap1 chan_rst_n", chan_rst_n, 4'b0011);
        chk("gap1 seq_busy", seq_busy, 1);
        do_restart("gap1 rs", base);
        run_and_check("gap1 rerun", base);

        // 5: reset pulse mid-HOLD restarts the hold count
        do_restart("hold", base);
        repeat (6) step();
        async_reset("async hold", base);
        run_and_check("post hold rst", base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
